adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Parametrised parallel-ADC front end: generates the converter clock, registers raw samples, reduces them to OUT_W bits by truncation or rounding, decimates, and captures a DEPTH-sample record into on-chip RAM on a software arm plus level trigger.
- Sits between the ADC pins and the display/measurement logic.
- Read-out is random access from the user side after capture completes.

Parameters:
- ADC_W, 10, raw converter width (>= OUT_W).
- OUT_W, 8, output sample width.
- DEPTH, 256, capture record length (power of two).
- AW, 8, buffer address width, log2(DEPTH).
- CLK_DIV, 1, clk cycles per ad_clk period (1, or even >= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- ad_data_in  in  ADC_W  converter data bus.
- ad_clk  out  1  converter clock.
- decim  in  8  keep one sample in (decim+1); sampled when arm is seen.
- round_en  in  1  0 = truncate, 1 = round-half-up with saturation.
- trig_mode  in  2  00 immediate, 01 rising, 10 falling, 11 immediate.
- trig_level  in  OUT_W  trigger threshold.
- arm  in  1  single-cycle start/restart pulse.
- busy  out  1  armed or capturing.
- done  out  1  record complete; held until next arm.
- sample_valid  out  1  one-cycle strobe per decimated sample.
- sample_data  out  OUT_W  live decimated sample.
- rd_addr  in  AW  buffer read address.
- rd_data  out  OUT_W  buffer data, registered, 1-cycle latency.

Behaviour:
- Reset values: busy, done, sample_valid, sample_data, rd_data = 0. For CLK_DIV>1, ad_clk = 0 and the divider = 0. Buffer contents are not reset.
- Clock, CLK_DIV=1: ad_clk = ~clk, combinational. The sample strobe is high every cycle.
- Clock, CLK_DIV>1:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - ad_clk = 1 when div_cnt < CLK_DIV/2.
  - Strobe is high when div_cnt == CLK_DIV-1, the last low cycle before the ad_clk rising edge.
- Pipeline:
  - Stage 1: raw <= ad_data_in on strobe.
  - Stage 2: conversion.
  - Decimated results appear on sample_data with sample_valid two clk edges after the strobe.
- Conversion:
  - trunc = raw[ADC_W-1 : ADC_W-OUT_W].
  - When round_en=1 and ADC_W>OUT_W: out = trunc + raw[ADC_W-OUT_W-1], saturating at all-ones, never wrapping.
  - When ADC_W == OUT_W: passthrough.
- Decimation:
  - dec_cnt loads decim on arm.
  - Each converted sample: if dec_cnt==0, the sample is kept and dec_cnt reloads; otherwise dec_cnt decrements.
  - decim=0 keeps every sample.
  - Outside busy, decimation runs with the last latched decim.
- FSM states IDLE, ARMED, CAPT, DONE:
  - IDLE: busy=0. arm -> ARMED, done<=0, wr_addr<=0, prev_valid<=0.
  - ARMED: busy=1, evaluated on each kept sample.
    - Immediate mode: that sample triggers.
    - Rising: triggers if prev_valid && prev < trig_level && cur >= trig_level.
    - Falling: triggers if prev_valid && prev >= trig_level && cur < trig_level.
    - prev <= cur and prev_valid <= 1 every kept sample.
    - On trigger: the triggering sample is written at address 0 -> CAPT, wr_addr = 1.
  - CAPT: each kept sample is written at wr_addr, then wr_addr increments. The write at DEPTH-1 -> DONE.
  - DONE: busy=0, done=1. arm -> ARMED, same actions as from IDLE.
- Arm while ARMED/CAPT restarts: wr_addr=0, prev_valid=0, decim relatched, state ARMED. The partial record is abandoned and done stays 0.
- Arm coinciding with a kept sample: arm wins and the sample is not evaluated.
- Reads:
  - Any time, dual-port RAM, rd_data = mem[rd_addr] one edge later.
  - A read and a write to the same address in the same cycle returns old data.
  - Contents are only guaranteed meaningful when done=1.
- trig_level and trig_mode are sampled live; changes while ARMED take effect on the next kept sample.
- Asynchronous reset mid-capture returns to IDLE with all outputs as at reset.

Decomposition:
- Shared package adc_pkg holds:
  - the trig_mode encodings (TRIG_IMM, TRIG_RISE, TRIG_FALL);
  - the FSM state encoding;
  - the saturating-round function.
- One sub-module is natural: capture_ram, a simple dual-port RAM of DEPTH x OUT_W with registered read and write port clk/we/waddr/wdata, inferable as block RAM.

Test Plan:
- Reset: with CLK_DIV=4, assert rst_n=0 mid-capture -> busy=0, done=0, ad_clk=0, sample_valid=0. After release, ad_clk has period 4 clk and is high 2 cycles.
- Rounding, round_en=1:
  - ad_data_in=10'h3FE -> sample_data=8'hFF, saturated.
  - 10'h102 -> 8'h41.
  - With round_en=0, 10'h102 -> 8'h40.
  - Each appears 2 edges after the strobe.
- Immediate capture: CLK_DIV=1, decim=0, ramp input 0,4,8,... (raw).
  - arm -> done after 256 kept samples.
  - rd_addr=5 -> rd_data = first captured value + 5 one cycle later.
- Rising trigger: trig_level=8'h80, sawtooth input.
  - mem[0] is the first sample >= 8'h80 following a sample < 8'h80.
  - A sample equal to 8'h80 directly after arm does not trigger (prev_valid=0).
- Decimation: decim=3, ramp incrementing 1 (8-bit) per sample -> consecutive buffer entries differ by 4. sample_valid duty is 1 in 4 strobes.
- Re-arm at wr_addr=100 in CAPT -> busy stays 1, done stays 0, new record restarts at address 0 and completes after the full 256 samples.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared encodings and sample-width reduction helper for the ADC capture front end.
// Pure definitions: no state, no latency, no flow control.
package adc_pkg;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Keeps the top out_w bits; optional round-half-up clamps at all-ones instead of wrapping.
    function automatic logic [31:0] sat_round(input logic [31:0] raw,
                                              input int          adc_w,
                                              input int          out_w,
                                              input logic        round_en);
        logic [31:0] trunc;
        logic [31:0] all_ones;
        logic [31:0] below;
        logic        half;
        trunc    = raw >> (adc_w - out_w);
        all_ones = (32'd1 << out_w) - 32'd1;
        half     = 1'b0;
        if (adc_w > out_w) begin
            below = raw >> (adc_w - out_w - 1);
            half  = below[0];
        end
        if (round_en && half && (trunc != all_ones)) begin
            trunc = trunc + 32'd1;
        end
        return trunc;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port DEPTH x DW record buffer, one write port and one registered read port.
// Read latency 1 clk, read-during-write returns old data; always accepts, no backpressure.
module capture_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// Parallel-ADC front end: converter clock, sample register, width reduction, decimation, triggered record capture.
// Sample out 2 clk edges after the strobe, readback 1 clk; free-running, no backpressure.
module adc_capture
    import adc_pkg::*;
#(
    parameter int ADC_W   = 10,
    parameter int OUT_W   = 8,
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] ad_data_in,
    output logic             ad_clk,
    input  logic [7:0]       decim,
    input  logic             round_en,
    input  logic [1:0]       trig_mode,
    input  logic [OUT_W-1:0] trig_level,
    input  logic             arm,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [OUT_W-1:0] sample_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [OUT_W-1:0] rd_data
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic strobe;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign ad_clk = ~clk;
            assign strobe = 1'b1;
        end else begin : g_div
            logic [DW-1:0] div_cnt_d;
            logic [DW-1:0] div_cnt_q;
            logic          ad_clk_d;
            logic          ad_clk_q;

            // ad_clk is registered from the next count so it tracks div_cnt yet still resets low.
            always_comb begin
                div_cnt_d = (div_cnt_q == DW'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
                ad_clk_d  = (div_cnt_d < DW'(CLK_DIV / 2));
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_cnt_q <= '0;
                    ad_clk_q  <= 1'b0;
                end else begin
                    div_cnt_q <= div_cnt_d;
                    ad_clk_q  <= ad_clk_d;
                end
            end

            assign ad_clk = ad_clk_q;
            assign strobe = (div_cnt_q == DW'(CLK_DIV - 1));
        end
    endgenerate

    logic [ADC_W-1:0] raw_d, raw_q;
    logic             raw_vld_d, raw_vld_q;
    logic [7:0]       decim_d, decim_q;
    logic [7:0]       dec_cnt_d, dec_cnt_q;
    logic             sample_valid_d, sample_valid_q;
    logic [OUT_W-1:0] sample_data_d, sample_data_q;
    logic [OUT_W-1:0] conv;
    logic             kept;

    always_comb begin
        raw_d          = strobe ? ad_data_in : raw_q;
        raw_vld_d      = strobe;
        conv           = OUT_W'(sat_round(32'(raw_q), ADC_W, OUT_W, round_en));
        kept           = 1'b0;
        decim_d        = decim_q;
        dec_cnt_d      = dec_cnt_q;
        // An arm restarts the decimation phase; the sample in flight that cycle is dropped.
        if (arm) begin
            decim_d   = decim;
            dec_cnt_d = decim;
        end else if (raw_vld_q) begin
            if (dec_cnt_q == 8'd0) begin
                kept      = 1'b1;
                dec_cnt_d = decim_q;
            end else begin
                dec_cnt_d = dec_cnt_q - 8'd1;
            end
        end
        sample_valid_d = kept;
        sample_data_d  = kept ? conv : sample_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q          <= '0;
            raw_vld_q      <= 1'b0;
            decim_q        <= '0;
            dec_cnt_q      <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
        end else begin
            raw_q          <= raw_d;
            raw_vld_q      <= raw_vld_d;
            decim_q        <= decim_d;
            dec_cnt_q      <= dec_cnt_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
        end
    end

    state_t           state_q;
    logic             busy_q, done_q;
    logic [AW-1:0]    wr_addr_q;
    logic [OUT_W-1:0] prev_q;
    logic             prev_vld_q;
    logic             trig;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;

    always_comb begin
        case (trig_mode)
            TRIG_RISE: trig = prev_vld_q && (prev_q <  trig_level) && (conv >= trig_level);
            TRIG_FALL: trig = prev_vld_q && (prev_q >= trig_level) && (conv <  trig_level);
            default:   trig = 1'b1;
        endcase
        ram_we    = kept && (((state_q == S_ARMED) && trig) || (state_q == S_CAPT));
        ram_waddr = (state_q == S_ARMED) ? '0 : wr_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_addr_q  <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (arm) begin
            state_q    <= S_ARMED;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            wr_addr_q  <= '0;
            prev_vld_q <= 1'b0;
        end else if (kept) begin
            case (state_q)
                S_ARMED: begin
                    prev_q     <= conv;
                    prev_vld_q <= 1'b1;
                    if (trig) begin
                        state_q   <= S_CAPT;
                        wr_addr_q <= AW'(1);
                    end
                end
                S_CAPT: begin
                    wr_addr_q <= wr_addr_q + 1'b1;
                    if (wr_addr_q == AW'(DEPTH - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    capture_ram #(
        .DW    (OUT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (conv),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;

endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: stream-level model with per-cycle compare on a CLK_DIV=1 instance,
// plus directed checks of rounding, reset and the divided converter clock on a CLK_DIV=4 instance.
module tb_adc_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // CLK_DIV = 1 instance
    logic       rst_n = 1'b0;
    logic [9:0] ad_data_in = '0;
    logic       ad_clk;
    logic [7:0] decim = '0;
    logic       round_en = 1'b0;
    logic [1:0] trig_mode = '0;
    logic [7:0] trig_level = '0;
    logic       arm = 1'b0;
    logic       busy, done, sample_valid;
    logic [7:0] sample_data;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;

    // CLK_DIV = 4 instance
    logic       r4_n = 1'b0;
    logic [9:0] d4_in = '0;
    logic       d4_clk;
    logic [7:0] d4_decim = '0;
    logic       d4_round = 1'b0;
    logic [1:0] d4_mode = '0;
    logic [7:0] d4_level = '0;
    logic       d4_arm = 1'b0;
    logic       d4_busy, d4_done, d4_vld;
    logic [7:0] d4_dat;
    logic [7:0] d4_raddr = '0;
    logic [7:0] d4_rd;

    adc_capture #(.ADC_W(10), .OUT_W(8), .DEPTH(256), .AW(8), .CLK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .ad_data_in(ad_data_in), .ad_clk(ad_clk),
        .decim(decim), .round_en(round_en), .trig_mode(trig_mode), .trig_level(trig_level),
        .arm(arm), .busy(busy), .done(done), .sample_valid(sample_valid),
        .sample_data(sample_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    adc_capture #(.ADC_W(10), .OUT_W(8), .DEPTH(256), .AW(8), .CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(r4_n), .ad_data_in(d4_in), .ad_clk(d4_clk),
        .decim(d4_decim), .round_en(d4_round), .trig_mode(d4_mode), .trig_level(d4_level),
        .arm(d4_arm), .busy(d4_busy), .done(d4_done), .sample_valid(d4_vld),
        .sample_data(d4_dat), .rd_addr(d4_raddr), .rd_data(d4_rd)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the CLK_DIV=1 instance, one converter sample per clk.
    function automatic int reduce(input int raw, input bit rnd);
        int t;
        t = raw / 4;
        if (rnd && (raw % 4) >= 2 && t < 255) t = t + 1;
        return t;
    endfunction

    bit m_have_raw, m_armed, m_capt, m_done, m_pv, m_hit, e_vld;
    int m_raw, m_dec, m_decim, m_idx, m_prev, m_cur, e_dat;
    int m_mem [256];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have_raw = 0; m_armed = 0; m_capt = 0; m_done = 0; m_pv = 0;
            m_dec = 0; m_decim = 0; m_idx = 0; e_vld = 0; e_dat = 0;
        end else begin
            e_vld = 0;
            if (arm) begin
                m_decim = decim; m_dec = decim;
                m_armed = 1; m_capt = 0; m_done = 0; m_idx = 0; m_pv = 0;
            end else if (m_have_raw) begin
                if (m_dec == 0) begin
                    m_dec = m_decim;
                    m_cur = reduce(m_raw, round_en);
                    e_vld = 1;
                    e_dat = m_cur;
                    if (m_armed) begin
                        case (trig_mode)
                            2'b01:   m_hit = m_pv && (m_prev < int'(trig_level)) && (m_cur >= int'(trig_level));
                            2'b10:   m_hit = m_pv && (m_prev >= int'(trig_level)) && (m_cur < int'(trig_level));
                            default: m_hit = 1;
                        endcase
                        m_prev = m_cur;
                        m_pv   = 1;
                        if (m_hit) begin
                            m_mem[0] = m_cur; m_idx = 1; m_armed = 0; m_capt = 1;
                        end
                    end else if (m_capt) begin
                        m_mem[m_idx] = m_cur;
                        m_idx++;
                        if (m_idx == 256) begin
                            m_capt = 0; m_done = 1;
                        end
                    end
                end else begin
                    m_dec--;
                end
            end
            m_raw = int'(ad_data_in);
            m_have_raw = 1;
        end
    end

    bit run_cmp = 0;
    always @(negedge clk) begin
        if (run_cmp && rst_n) begin
            check("busy", 32'(busy), 32'(m_armed | m_capt));
            check("done", 32'(done), 32'(m_done));
            check("sample_valid", 32'(sample_valid), 32'(e_vld));
            if (e_vld) check("sample_data", 32'(sample_data), 32'(e_dat));
        end
    end

    // Stimulus: optional prefix table, then a ramp of 8-bit codes (raw = code*4).
    int pre [$];
    int ramp_val = 0;
    int ramp_inc = 1;

    task automatic cyc(input bit a);
        int v;
        @(negedge clk);
        arm = a;
        if (pre.size() > 0) begin
            v = pre.pop_front();
        end else begin
            v = ramp_val;
            ramp_val = (ramp_val + ramp_inc) & 255;
        end
        ad_data_in = 10'(v * 4);
    endtask

    task automatic wait_done(output int c);
        c = 0;
        do begin
            cyc(0);
            c++;
        end while (!done && c < 3000);
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic rd_chk(input string name, input int addr, input int exp);
        cyc(0);
        rd_addr = 8'(addr);
        cyc(0);
        check(name, 32'(rd_data), 32'(exp));
        check({name, "_model"}, 32'(rd_data), 32'(m_mem[addr]));
    endtask

    task automatic d4_sample(input string name, input logic [9:0] din, input logic rnd, input logic [7:0] exp);
        logic prev;
        bit   rose;
        int   n;
        @(negedge clk);
        d4_in = din;
        d4_round = rnd;
        prev = d4_clk;
        n = 0;
        rose = 0;
        do begin
            @(negedge clk);
            n++;
            rose = (prev == 1'b0) && (d4_clk == 1'b1);
            prev = d4_clk;
        end while (!rose && n < 10);
        check({name, "_adclk_rise"}, 32'(rose), 32'd1);
        check({name, "_vld_at_rise"}, 32'(d4_vld), 32'd0);
        @(negedge clk);
        check({name, "_vld"}, 32'(d4_vld), 32'd1);
        check({name, "_dat"}, 32'(d4_dat), 32'(exp));
    endtask

    initial begin
        int c;
        int nv;
        logic [11:0] pat;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vld", 32'(sample_valid), 32'd0);
        check("rst_dat", 32'(sample_data), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst4_adclk", 32'(d4_clk), 32'd0);
        rst_n = 1'b1;
        r4_n  = 1'b1;
        run_cmp = 1;

        @(posedge clk); #2;
        check("adclk_div1_low", 32'(ad_clk), 32'd0);
        @(negedge clk); #2;
        check("adclk_div1_high", 32'(ad_clk), 32'd1);

        // Immediate capture of a ramp starting at code 0 on the arm cycle.
        repeat (5) cyc(0);
        ramp_val = 0; ramp_inc = 1;
        cyc(1);
        wait_done(c);
        check("imm_cycles", 32'(c), 32'd257);
        rd_chk("imm_mem0", 0, 8'h00);
        rd_chk("imm_mem5", 5, 8'h05);
        rd_chk("imm_mem255", 255, 8'hFF);

        // Rising trigger: the 0x80 right after arm must not fire; 0x70 -> 0x88 does.
        trig_mode = 2'b01; trig_level = 8'h80;
        pre = '{8'h80, 8'h90, 8'hA0, 8'h10, 8'h30, 8'h50, 8'h70, 8'h88};
        ramp_val = 8'h8B; ramp_inc = 3;
        cyc(1);
        wait_done(c);
        check("rise_cycles", 32'(c), 32'd264);
        rd_chk("rise_mem0", 0, 8'h88);
        rd_chk("rise_mem1", 1, 8'h8B);
        rd_chk("rise_mem2", 2, 8'h8E);

        // Falling trigger: 0x90 -> 0x60 crosses downward.
        trig_mode = 2'b10;
        pre = '{8'h70, 8'h90, 8'h60};
        ramp_val = 8'h61; ramp_inc = 1;
        cyc(1);
        wait_done(c);
        check("fall_cycles", 32'(c), 32'd259);
        rd_chk("fall_mem0", 0, 8'h60);
        rd_chk("fall_mem1", 1, 8'h61);

        // Decimation by 4: first kept sample is the 4th after arm.
        trig_mode = 2'b00; decim = 8'd3;
        ramp_val = 0; ramp_inc = 1;
        cyc(1);
        repeat (4) cyc(0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0);
            if (sample_valid) nv++;
        end
        check("decim_duty", 32'(nv), 32'd10);
        wait_done(c);
        check("decim_cycles", 32'(c), 32'(1025 - 44));
        rd_chk("decim_mem0", 0, 8'h03);
        rd_chk("decim_mem1", 1, 8'h07);
        rd_chk("decim_mem2", 2, 8'h0B);
        rd_chk("decim_mem255", 255, 8'hFF);

        // Re-arm with wr_addr at 100 mid-capture.
        decim = 8'd0;
        ramp_val = 0; ramp_inc = 1;
        cyc(1);
        repeat (100) cyc(0);
        check("rearm_busy_before", 32'(busy), 32'd1);
        check("rearm_done_before", 32'(done), 32'd0);
        ramp_val = 8'h40;
        cyc(1);
        wait_done(c);
        check("rearm_cycles", 32'(c), 32'd257);
        rd_chk("rearm_mem0", 0, 8'h40);
        rd_chk("rearm_mem100", 100, 8'hA4);
        rd_chk("rearm_mem255", 255, 8'h3F);

        // Conversion on the divided-clock instance.
        d4_sample("rnd_3FE", 10'h3FE, 1'b1, 8'hFF);
        d4_sample("rnd_102", 10'h102, 1'b1, 8'h41);
        d4_sample("trunc_102", 10'h102, 1'b0, 8'h40);
        d4_sample("rnd_1FE", 10'h1FE, 1'b1, 8'h80);
        d4_sample("rnd_3FA", 10'h3FA, 1'b1, 8'hFF);
        d4_sample("rnd_003", 10'h003, 1'b1, 8'h01);

        // Asynchronous reset mid-capture, then the divider restarts from 0.
        @(negedge clk); d4_arm = 1'b1;
        @(negedge clk); d4_arm = 1'b0;
        repeat (20) @(negedge clk);
        check("d4_busy_capturing", 32'(d4_busy), 32'd1);
        r4_n = 1'b0;
        #1;
        check("d4_rst_busy", 32'(d4_busy), 32'd0);
        check("d4_rst_done", 32'(d4_done), 32'd0);
        check("d4_rst_adclk", 32'(d4_clk), 32'd0);
        check("d4_rst_vld", 32'(d4_vld), 32'd0);
        @(negedge clk);
        r4_n = 1'b1;
        pat = 12'b1001_1001_1001;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("d4_adclk_%0d", i), 32'(d4_clk), 32'(pat[i]));
        end

        repeat (2) @(negedge clk);
        run_cmp = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
